// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack beside the ID stage.
// CALL pushes the return PC; RET reads top-of-stack combinationally and pops.
// Overflow/underflow are sticky until clr_err.
//
// Optional feature macro: RAS_WRAP_EN
//   defined   -> push while full overwrites the oldest entry
//   undefined -> push while full is dropped
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push, pop   : decode-stage strobes
//   push_addr   : return address to store
//   clr_err     : clears sticky overflow/underflow
//   ret_addr    : top-of-stack (0 when empty), combinational
//   empty, full : occupancy status
//   count       : number of valid entries
//   overflow    : sticky, push while full
//   underflow   : sticky, pop while empty
module ret_addr_stack #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic                     clr_err,
    output logic [ADDR_W-1:0]        ret_addr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              ovf_set;
    logic              unf_set;

    // Status from registered occupancy
    assign empty    = (cnt_q == CNT_W'(0));
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign underflow = unf_q;

    // Top-of-stack sits just below the write pointer (wraps mod DEPTH)
    assign top_idx  = sp_q - PTR_W'(1);
    assign ret_addr = empty ? '0 : mem[top_idx];

    // Next-state selection: exactly one push/pop case applies per cycle
    always_comb begin
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop) begin
            if (!empty) begin
                // Tail call: replace the top entry in place
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                // Empty stack degenerates to a plain push, flagged as underflow
                unf_set = 1'b1;
                wr_en   = 1'b1;
                sp_d    = sp_q + PTR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else if (push) begin
            if (!full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + PTR_W'(1);
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
                // Overwrite oldest entry; newest DEPTH returns stay valid
                wr_en = 1'b1;
                sp_d  = sp_q + PTR_W'(1);
`else
                wr_en = 1'b0;
`endif
            end
        end else if (pop) begin
            if (!empty) begin
                sp_d  = sp_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                unf_set = 1'b1;
            end
        end
        // A setting event in the same cycle beats clr_err
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        unf_d = (unf_q & ~clr_err) | unf_set;
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents need no reset
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack with hand-computed expectations.
module tb_ret_addr_stack;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              clr_err;
    logic [ADDR_W-1:0] ret_addr;
    logic              empty;
    logic              full;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    ret_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .clr_err   (clr_err),
        .ret_addr  (ret_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample #1 after the edge
    task automatic set_in(input logic p, input logic q, input logic [ADDR_W-1:0] a, input logic c);
        push = p; pop = q; push_addr = a; clr_err = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; push_addr = '0; clr_err = 1'b0;
    endtask

    task automatic check_idle_empty(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ret"},   32'(ret_addr), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0; clr_err = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle_empty("rst");
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_unf",  32'(underflow), 32'd0);

        // Reset wins over a concurrent push
        set_in(1'b1, 1'b0, 19'h55, 1'b0); tick();
        check("pre_rst_count", 32'(count), 32'd1);
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 19'h66, 1'b0); tick();
        rst_n = 1'b1;
        check_idle_empty("rst_push");

        // Basic LIFO order, read in the pop cycle
        set_in(1'b1, 1'b0, 19'h10, 1'b0); tick();
        set_in(1'b1, 1'b0, 19'h20, 1'b0); tick();
        set_in(1'b1, 1'b0, 19'h30, 1'b0); tick();
        check("lifo_count", 32'(count), 32'd3);
        check("lifo_top",   32'(ret_addr), 32'h30);
        for (int i = 3; i >= 1; i--) begin
            set_in(1'b0, 1'b1, '0, 1'b0);
            check($sformatf("lifo_pop%0d", i), 32'(ret_addr), 32'(i * 16));
            tick();
        end
        check("lifo_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, then one more push
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, 1'b0, 19'(i), 1'b0); tick();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf0", 32'(overflow), 32'd0);
        set_in(1'b1, 1'b0, 19'h9, 1'b0); tick();
        check("ovf_full",  32'(full), 32'd1);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
`ifdef RAS_WRAP_EN
        check("ovf_top", 32'(ret_addr), 32'h9);
        for (int i = 9; i >= 2; i--) begin
            set_in(1'b0, 1'b1, '0, 1'b0);
            check($sformatf("ovf_pop%0d", i), 32'(ret_addr), 32'(i));
            tick();
        end
`else
        check("ovf_top", 32'(ret_addr), 32'h8);
        for (int i = 8; i >= 1; i--) begin
            set_in(1'b0, 1'b1, '0, 1'b0);
            check($sformatf("ovf_pop%0d", i), 32'(ret_addr), 32'(i));
            tick();
        end
`endif
        check("ovf_drained", 32'(empty), 32'd1);
        check("ovf_sticky",  32'(overflow), 32'd1);

        // Sticky flag clear and underflow priority
        set_in(1'b0, 1'b0, '0, 1'b1); tick();
        check("clr_ovf", 32'(overflow), 32'd0);
        set_in(1'b0, 1'b1, '0, 1'b0); tick();
        check("unf_set",   32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        set_in(1'b0, 1'b0, '0, 1'b1); tick();
        check("unf_clr", 32'(underflow), 32'd0);
        set_in(1'b0, 1'b1, '0, 1'b1); tick();
        check("unf_wins", 32'(underflow), 32'd1);
        set_in(1'b0, 1'b0, '0, 1'b1); tick();

        // Tail call replaces top
        set_in(1'b1, 1'b0, 19'h100, 1'b0); tick();
        set_in(1'b1, 1'b0, 19'h200, 1'b0); tick();
        set_in(1'b1, 1'b1, 19'h300, 1'b0);
        check("tail_ret_pre", 32'(ret_addr), 32'h200);
        tick();
        check("tail_count", 32'(count), 32'd2);
        check("tail_top",   32'(ret_addr), 32'h300);
        set_in(1'b0, 1'b1, '0, 1'b0); tick();
        check("tail_after", 32'(ret_addr), 32'h100);
        check("tail_unf",   32'(underflow), 32'd0);
        set_in(1'b0, 1'b1, '0, 1'b0); tick();
        check_idle_empty("tail_drain");

        // Push+pop on empty acts as a push and flags underflow
        set_in(1'b1, 1'b1, 19'h7, 1'b0); tick();
        check("pp_count", 32'(count), 32'd1);
        check("pp_top",   32'(ret_addr), 32'h7);
        check("pp_unf",   32'(underflow), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
